// File: rtl/input_cond_pkg.sv
// Shared types and sizing helpers for the player-input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } ch_state_e;

  function automatic int cnt_width(
    input int deb,
    input int hold,
    input int rpt
  );
    int m;
    m = (deb > hold + rpt) ? deb : hold + rpt;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioner channel: synchroniser, debounce FSM and
// press/auto-repeat counter.
module input_conditioner_ch
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int HOLD        = 16,
  parameter int REPEAT      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  output logic press,
  output logic release_pulse,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE, HOLD, REPEAT);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] D_C  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] H_C  = CW'(HOLD);
  localparam logic [CW-1:0] HR_C = CW'(HOLD + REPEAT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  ch_state_e              state;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;

  assign s       = sync[SYNC_STAGES-1];
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync          <= '0;
      state         <= RELEASED;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      level         <= 1'b0;
    end else begin
      sync[0] <= raw;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync[k] <= sync[k-1];
      press         <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (s) begin
            if (DEBOUNCE == 1) begin
              state <= PRESSED;
              press <= 1'b1;
              level <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= PRESS_WAIT;
              cnt   <= ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt_inc == D_C) begin
            state <= PRESSED;
            press <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!s) begin
            if (DEBOUNCE == 1) begin
              state         <= RELEASED;
              release_pulse <= 1'b1;
              level         <= 1'b0;
              cnt           <= '0;
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= ONE;
            end
          end else if (repeat_en && cnt_inc >= HR_C) begin
            // fold back to HOLD so repeats recur every REPEAT cycles
            press <= 1'b1;
            cnt   <= H_C;
          end else begin
            cnt <= cnt_inc;
            if (repeat_en && cnt_inc == H_C)
              press <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt_inc == D_C) begin
            state         <= RELEASED;
            release_pulse <= 1'b1;
            level         <= 1'b0;
            cnt           <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_input_conditioner.sv
// N-channel player-input conditioner; release_pulse carries the
// release event since "release" is a reserved word.
module multi_input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int HOLD        = 16,
  parameter int REPEAT      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] player_input,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] level,
  output logic            any_press
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE),
      .HOLD       (HOLD),
      .REPEAT     (REPEAT)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .raw          (player_input[i]),
      .repeat_en    (repeat_en[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .level        (level[i])
    );
  end

  assign any_press = |press;

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Self-checking bench for multi_input_conditioner (default params).
module tb_multi_input_conditioner;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int HLD = 16;
  localparam int REP = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pin = '0;
  logic [N-1:0] ren = '0;
  logic [N-1:0] press;
  logic [N-1:0] rel;
  logic [N-1:0] level;
  logic         any_press;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  multi_input_conditioner dut (
    .clk          (clk),
    .reset        (rst_n),
    .player_input (pin),
    .repeat_en    (ren),
    .press        (press),
    .release_pulse(rel),
    .level        (level),
    .any_press    (any_press)
  );

  always #5 clk = ~clk;

  // behavioural model: run = consecutive cycles s disagrees with
  // the debounced level, held = cycles held since (re)press
  bit       m_sync [N][SS];
  int       m_run  [N];
  int       m_held [N];
  bit       m_lvl  [N];
  bit       m_p    [N];
  bit       m_r    [N];

  // per-window statistics for directed checks
  int pcnt [N];
  int rcnt [N];
  int fp   [N];
  int fr   [N];
  int acnt;

  function automatic void model_edge();
    bit s;
    for (int i = 0; i < N; i++) begin
      m_p[i] = 0;
      m_r[i] = 0;
      if (!rst_n) begin
        for (int k = 0; k < SS; k++) m_sync[i][k] = 0;
        m_run[i]  = 0;
        m_held[i] = 0;
        m_lvl[i]  = 0;
        continue;
      end
      s = m_sync[i][SS-1];
      if (!m_lvl[i]) begin
        if (s) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i]  = 1;
            m_p[i]    = 1;
            m_run[i]  = 0;
            m_held[i] = 0;
          end
        end else m_run[i] = 0;
      end else if (s) begin
        if (m_run[i] > 0) begin
          m_run[i]  = 0;
          m_held[i] = 0;
        end else begin
          m_held[i]++;
          if (ren[i] && m_held[i] >= HLD &&
              (m_held[i] - HLD) % REP == 0)
            m_p[i] = 1;
        end
      end else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = 0;
          m_r[i]   = 1;
          m_run[i] = 0;
        end
      end
      for (int k = SS - 1; k > 0; k--)
        m_sync[i][k] = m_sync[i][k-1];
      m_sync[i][0] = pin[i];
    end
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0;
      rcnt[i] = 0;
      fp[i]   = -1;
      fr[i]   = -1;
    end
    acnt = 0;
  endtask

  task automatic step();
    logic [N-1:0] ep, er, el;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      ep[i] = m_p[i];
      er[i] = m_r[i];
      el[i] = m_lvl[i];
    end
    chk("model_press", int'(press), int'(ep));
    chk("model_release", int'(rel), int'(er));
    chk("model_level", int'(level), int'(el));
    chk("model_any", int'(any_press), int'(|ep));
    for (int i = 0; i < N; i++) begin
      if (press[i]) begin
        pcnt[i]++;
        if (fp[i] < 0) fp[i] = cyc;
      end
      if (rel[i]) begin
        rcnt[i]++;
        if (fr[i] < 0) fr[i] = cyc;
      end
    end
    if (any_press) acnt++;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] ren;
    int           high;
    int           np;
    int           nr;
    int           first;
    int           roff;
  } vec_t;

  vec_t vt [7];

  initial begin
    int t0;
    vt[0] = '{4'b0001, 4'b0000, 10, 1, 1, 5, 15};
    vt[1] = '{4'b0100, 4'b0100, 50, 5, 1, 5, 55};
    vt[2] = '{4'b1001, 4'b0000, 8, 1, 1, 5, 13};
    vt[3] = '{4'b0010, 4'b0010, 3, 0, 0, -1, -1};
    vt[4] = '{4'b0010, 4'b0010, 4, 1, 1, 5, 9};
    vt[5] = '{4'b0100, 4'b0100, 21, 2, 1, 5, 26};
    vt[6] = '{4'b0100, 4'b0100, 16, 1, 1, 5, 21};

    // reset with all inputs held high
    rst_n = 0;
    pin   = 4'b1111;
    clear_stats();
    repeat (3) begin
      step();
      chk("rst_outs", int'({press, rel, level, any_press}), 0);
    end
    rst_n = 1;
    t0 = cyc + 1;
    repeat (8) step();
    for (int i = 0; i < N; i++)
      chk("rst_first_press", fp[i] - t0, 5);
    chk("rst_any_cnt", acnt, 1);
    pin = '0;
    repeat (12) step();

    // bounce on ch1
    clear_stats();
    pin = 4'b0010;
    repeat (3) step();
    pin = 4'b0000;
    step();
    t0 = cyc + 1;
    pin = 4'b0010;
    repeat (12) step();
    chk("bounce_first", fp[1] - t0, 5);
    chk("bounce_cnt", pcnt[1], 1);
    pin = '0;
    repeat (12) step();

    // reset while ch0 is held
    pin = 4'b0001;
    repeat (10) step();
    chk("hold_level", int'(level[0]), 1);
    clear_stats();
    rst_n = 0;
    pin   = '0;
    step();
    chk("midrst_outs", int'({press, rel, level, any_press}), 0);
    rst_n = 1;
    repeat (10) step();
    chk("midrst_norel", rcnt[0], 0);

    // table-driven press/hold/release windows
    foreach (vt[v]) begin
      clear_stats();
      ren = vt[v].ren;
      t0  = cyc + 1;
      pin = vt[v].mask;
      repeat (vt[v].high) step();
      pin = '0;
      repeat (25) step();
      for (int i = 0; i < N; i++) begin
        if (vt[v].mask[i]) begin
          chk($sformatf("v%0d_np%0d", v, i), pcnt[i], vt[v].np);
          chk($sformatf("v%0d_nr%0d", v, i), rcnt[i], vt[v].nr);
          if (vt[v].np > 0)
            chk($sformatf("v%0d_fp%0d", v, i), fp[i] - t0,
                vt[v].first);
          if (vt[v].nr > 0)
            chk($sformatf("v%0d_fr%0d", v, i), fr[i] - t0,
                vt[v].roff);
        end else begin
          chk($sformatf("v%0d_quiet%0d", v, i),
              pcnt[i] + rcnt[i], 0);
        end
      end
      chk($sformatf("v%0d_any", v), acnt, vt[v].np);
    end

    // randomized slow-toggling inputs against the model
    ren = 4'($urandom);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(11) == 0) pin[i] = ~pin[i];
      rst_n = ($urandom_range(599) != 0);
      step();
    end
    rst_n = 1;
    pin = '0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
